// File: rtl/core_mem_ctrl_ws.sv
// core_mem_ctrl_ws
//   Memory controller for the core. Arbitrates ROM fetches and RAM accesses
//   and serves them from internal RAM (byte or bit addressed), the internal
//   synchronous ROM macro, or the external bus. External accesses run a
//   SETUP / STROBE / HOLD sequence with a programmable number of extra strobe
//   cycles. Every access ends with a one-cycle ready pulse.
//
// Ports
//   mem_ctrl_clk_i / mem_ctrl_rst_i        clock, synchronous active-high reset
//   mem_ctrl_rom_rd_b_i                    fetch request (active low)
//   mem_ctrl_ram_rd_b_i / _ram_wr_b_i      RAM read / write requests (active low)
//   mem_ctrl_bit_byte_flag_i               1 = bit access to internal RAM
//   mem_ctrl_ext_ram_i                     1 = RAM access goes to the external bus
//   mem_ctrl_rom_addr_i / _ram_addr_i      fetch address / RAM byte-or-bit address
//   mem_ctrl_ram_data_i                    write data (bit write uses [0])
//   mem_ctrl_ws_cfg_i                      extra external strobe cycles
//   mem_ctrl_ready_o                       one-cycle completion pulse
//   mem_ctrl_rom_data_o / _ram_data_o      read results, valid with ready
//   mem_ctrl_irom_*                        internal ROM macro interface
//   mem_ctrl_bus_ctrl_*                    external bus interface
//
// state       | meaning
// S_IDLE      | waiting for a request, latches operands on acceptance
// S_RAM       | internal RAM access (bit write: read phase)
// S_BIT_WB    | bit write: merged byte written back
// S_IROM      | internal ROM selected
// S_IROM_DATA | internal ROM data presented, registered at end of cycle
// S_SETUP     | external address valid, strobes high
// S_STROBE    | external strobe low for 1+ws cycles
// S_HOLD      | external strobe high, address/data held
// S_DONE      | ready pulse
module core_mem_ctrl_ws #(
  parameter int                DATA_W        = 8,
  parameter int                ROM_AW        = 16,
  parameter int                RAM_AW        = 8,
  parameter int                INT_ROM_DEPTH = 4096,
  parameter int                WS_W          = 3,
  parameter logic [RAM_AW-1:0] BIT_BASE      = 'h20
) (
  input  logic              mem_ctrl_clk_i,
  input  logic              mem_ctrl_rst_i,
  input  logic              mem_ctrl_rom_rd_b_i,
  input  logic              mem_ctrl_ram_rd_b_i,
  input  logic              mem_ctrl_ram_wr_b_i,
  input  logic              mem_ctrl_bit_byte_flag_i,
  input  logic              mem_ctrl_ext_ram_i,
  input  logic [ROM_AW-1:0] mem_ctrl_rom_addr_i,
  input  logic [RAM_AW-1:0] mem_ctrl_ram_addr_i,
  input  logic [DATA_W-1:0] mem_ctrl_ram_data_i,
  input  logic [WS_W-1:0]   mem_ctrl_ws_cfg_i,
  output logic              mem_ctrl_ready_o,
  output logic [DATA_W-1:0] mem_ctrl_rom_data_o,
  output logic [DATA_W-1:0] mem_ctrl_ram_data_o,
  output logic              mem_ctrl_irom_cs_b_o,
  output logic [ROM_AW-1:0] mem_ctrl_irom_addr_o,
  input  logic [DATA_W-1:0] mem_ctrl_irom_data_i,
  input  logic              mem_ctrl_bus_ctrl_ea_b_i,
  input  logic [DATA_W-1:0] mem_ctrl_bus_ctrl_data_i,
  output logic [DATA_W-1:0] mem_ctrl_bus_ctrl_data_o,
  output logic              mem_ctrl_bus_ctrl_data_oe_o,
  output logic [ROM_AW-1:0] mem_ctrl_bus_ctrl_addr_o,
  output logic              mem_ctrl_bus_ctrl_ext_rom_rd_b_o,
  output logic              mem_ctrl_bus_ctrl_ext_ram_rd_b_o,
  output logic              mem_ctrl_bus_ctrl_ext_ram_wr_b_o
);

  typedef enum logic [3:0] {
    S_IDLE, S_RAM, S_BIT_WB, S_IROM, S_IROM_DATA,
    S_SETUP, S_STROBE, S_HOLD, S_DONE
  } state_t;

  typedef enum logic [1:0] {OP_WR, OP_RD, OP_FETCH} op_t;

  localparam logic [ROM_AW:0] IROM_LIMIT = (ROM_AW+1)'(INT_ROM_DEPTH);

  state_t state_q, state_d;
  op_t    op_q, acc_op;

  logic              bit_q;
  logic [RAM_AW-1:0] ram_addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [WS_W-1:0]   cnt_q;
  logic [ROM_AW-1:0] bus_addr_q;
  logic [ROM_AW-1:0] irom_addr_q;
  logic [DATA_W-1:0] rmw_q;
  logic [DATA_W-1:0] rom_data_q;
  logic [DATA_W-1:0] ram_data_q;

  logic [DATA_W-1:0] mem_q [2**RAM_AW];

  logic              accept, acc_ext, fetch_ext;
  logic [RAM_AW-1:0] bit_byte;
  logic [2:0]        bit_idx;
  logic [DATA_W-1:0] rmw_merged;

  logic              mem_we;
  logic [RAM_AW-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;

  logic ready, irom_cs_b, rom_rd_b, ram_rd_b, ram_wr_b, data_oe;

  // Arbitration of the raw requests: write beats read beats fetch.
  assign fetch_ext = ~mem_ctrl_bus_ctrl_ea_b_i
                   | ({1'b0, mem_ctrl_rom_addr_i} >= IROM_LIMIT);
  assign accept    = ~mem_ctrl_ram_wr_b_i | ~mem_ctrl_ram_rd_b_i | ~mem_ctrl_rom_rd_b_i;

  always_comb begin
    acc_op  = OP_FETCH;
    acc_ext = fetch_ext;
    if (!mem_ctrl_ram_wr_b_i) begin
      acc_op  = OP_WR;
      acc_ext = mem_ctrl_ext_ram_i;
    end else if (!mem_ctrl_ram_rd_b_i) begin
      acc_op  = OP_RD;
      acc_ext = mem_ctrl_ext_ram_i;
    end
  end

  // Low half of the bit space maps onto BIT_BASE..BIT_BASE+15, the upper
  // half onto every eighth byte from the top half of RAM.
  assign bit_idx  = ram_addr_q[2:0];
  assign bit_byte = ram_addr_q[RAM_AW-1]
                  ? {ram_addr_q[RAM_AW-1:3], 3'b000}
                  : BIT_BASE + {{4{1'b0}}, ram_addr_q[RAM_AW-2:3]};

  always_comb begin
    rmw_merged          = rmw_q;
    rmw_merged[bit_idx] = wdata_q[0];
  end

  always_comb begin
    state_d   = state_q;
    ready     = 1'b0;
    irom_cs_b = 1'b1;
    rom_rd_b  = 1'b1;
    ram_rd_b  = 1'b1;
    ram_wr_b  = 1'b1;
    data_oe   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (acc_ext)               state_d = S_SETUP;
          else if (acc_op == OP_FETCH) state_d = S_IROM;
          else                       state_d = S_RAM;
        end
      end
      S_RAM:       state_d = (op_q == OP_WR && bit_q) ? S_BIT_WB : S_DONE;
      S_BIT_WB:    state_d = S_DONE;
      S_IROM: begin
        irom_cs_b = 1'b0;
        state_d   = S_IROM_DATA;
      end
      S_IROM_DATA: state_d = S_DONE;
      S_SETUP: begin
        data_oe = (op_q == OP_WR);
        state_d = S_STROBE;
      end
      S_STROBE: begin
        data_oe  = (op_q == OP_WR);
        rom_rd_b = (op_q != OP_FETCH);
        ram_rd_b = (op_q != OP_RD);
        ram_wr_b = (op_q != OP_WR);
        if (cnt_q == '0) state_d = S_HOLD;
      end
      S_HOLD: begin
        data_oe = (op_q == OP_WR);
        state_d = S_DONE;
      end
      S_DONE: begin
        ready   = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = ram_addr_q;
    mem_wdata = wdata_q;
    if (state_q == S_RAM && op_q == OP_WR && !bit_q) mem_we = 1'b1;
    if (state_q == S_BIT_WB) begin
      mem_we    = 1'b1;
      mem_waddr = bit_byte;
      mem_wdata = rmw_merged;
    end
    if (mem_ctrl_rst_i) mem_we = 1'b0;
  end

  // RAM contents have no reset so they survive a controller reset.
  always_ff @(posedge mem_ctrl_clk_i) begin
    if (mem_we) mem_q[mem_waddr] <= mem_wdata;
  end

  always_ff @(posedge mem_ctrl_clk_i) begin
    if (mem_ctrl_rst_i) begin
      state_q     <= S_IDLE;
      op_q        <= OP_RD;
      bit_q       <= 1'b0;
      ram_addr_q  <= '0;
      wdata_q     <= '0;
      cnt_q       <= '0;
      bus_addr_q  <= '0;
      irom_addr_q <= '0;
      rmw_q       <= '0;
      rom_data_q  <= '0;
      ram_data_q  <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            op_q       <= acc_op;
            // External RAM is always a byte access.
            bit_q      <= mem_ctrl_bit_byte_flag_i & ~acc_ext & (acc_op != OP_FETCH);
            ram_addr_q <= mem_ctrl_ram_addr_i;
            wdata_q    <= mem_ctrl_ram_data_i;
            cnt_q      <= mem_ctrl_ws_cfg_i;
            if (acc_ext) begin
              bus_addr_q <= (acc_op == OP_FETCH) ? mem_ctrl_rom_addr_i
                          : {{(ROM_AW-RAM_AW){1'b0}}, mem_ctrl_ram_addr_i};
            end
            if (!acc_ext && acc_op == OP_FETCH) irom_addr_q <= mem_ctrl_rom_addr_i;
          end
        end
        S_RAM: begin
          if (op_q == OP_RD) begin
            ram_data_q <= bit_q ? {{(DATA_W-1){1'b0}}, mem_q[bit_byte][bit_idx]}
                                : mem_q[ram_addr_q];
          end else if (bit_q) begin
            rmw_q <= mem_q[bit_byte];
          end
        end
        S_IROM_DATA: rom_data_q <= mem_ctrl_irom_data_i;
        S_STROBE: begin
          if (cnt_q == '0) begin
            if (op_q == OP_RD)         ram_data_q <= mem_ctrl_bus_ctrl_data_i;
            else if (op_q == OP_FETCH) rom_data_q <= mem_ctrl_bus_ctrl_data_i;
          end else begin
            cnt_q <= cnt_q - {{(WS_W-1){1'b0}}, 1'b1};
          end
        end
        default: ;
      endcase
    end
  end

  assign mem_ctrl_ready_o                 = ready;
  assign mem_ctrl_rom_data_o              = rom_data_q;
  assign mem_ctrl_ram_data_o              = ram_data_q;
  assign mem_ctrl_irom_cs_b_o             = irom_cs_b;
  assign mem_ctrl_irom_addr_o             = irom_addr_q;
  assign mem_ctrl_bus_ctrl_data_o         = wdata_q;
  assign mem_ctrl_bus_ctrl_data_oe_o      = data_oe;
  assign mem_ctrl_bus_ctrl_addr_o         = bus_addr_q;
  assign mem_ctrl_bus_ctrl_ext_rom_rd_b_o = rom_rd_b;
  assign mem_ctrl_bus_ctrl_ext_ram_rd_b_o = ram_rd_b;
  assign mem_ctrl_bus_ctrl_ext_ram_wr_b_o = ram_wr_b;

endmodule

// File: tb/tb_core_mem_ctrl_ws.sv
module tb_core_mem_ctrl_ws;

  localparam int K_NONE = 0;
  localparam int K_RAM  = 1;
  localparam int K_ROM  = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        rom_rd_b, ram_rd_b, ram_wr_b, bit_flag, ext_ram, ea_b;
  logic [15:0] rom_addr;
  logic [7:0]  ram_addr, ram_wdata;
  logic [2:0]  ws;
  logic        ready;
  logic [7:0]  rom_data, ram_rdata;
  logic        irom_cs_b;
  logic [15:0] irom_addr;
  logic [7:0]  irom_data = 8'h00;
  logic [7:0]  bus_din, bus_dout;
  logic        oe;
  logic [15:0] bus_addr;
  logic        ext_rom_rd_b, ext_ram_rd_b, ext_ram_wr_b;

  always #5 clk = ~clk;

  core_mem_ctrl_ws dut (
    .mem_ctrl_clk_i                   (clk),
    .mem_ctrl_rst_i                   (rst),
    .mem_ctrl_rom_rd_b_i              (rom_rd_b),
    .mem_ctrl_ram_rd_b_i              (ram_rd_b),
    .mem_ctrl_ram_wr_b_i              (ram_wr_b),
    .mem_ctrl_bit_byte_flag_i         (bit_flag),
    .mem_ctrl_ext_ram_i               (ext_ram),
    .mem_ctrl_rom_addr_i              (rom_addr),
    .mem_ctrl_ram_addr_i              (ram_addr),
    .mem_ctrl_ram_data_i              (ram_wdata),
    .mem_ctrl_ws_cfg_i                (ws),
    .mem_ctrl_ready_o                 (ready),
    .mem_ctrl_rom_data_o              (rom_data),
    .mem_ctrl_ram_data_o              (ram_rdata),
    .mem_ctrl_irom_cs_b_o             (irom_cs_b),
    .mem_ctrl_irom_addr_o             (irom_addr),
    .mem_ctrl_irom_data_i             (irom_data),
    .mem_ctrl_bus_ctrl_ea_b_i         (ea_b),
    .mem_ctrl_bus_ctrl_data_i         (bus_din),
    .mem_ctrl_bus_ctrl_data_o         (bus_dout),
    .mem_ctrl_bus_ctrl_data_oe_o      (oe),
    .mem_ctrl_bus_ctrl_addr_o         (bus_addr),
    .mem_ctrl_bus_ctrl_ext_rom_rd_b_o (ext_rom_rd_b),
    .mem_ctrl_bus_ctrl_ext_ram_rd_b_o (ext_ram_rd_b),
    .mem_ctrl_bus_ctrl_ext_ram_wr_b_o (ext_ram_wr_b)
  );

  // Internal ROM macro: one-cycle latency, content = lo ^ hi ^ 3C.
  always @(posedge clk) if (!irom_cs_b) irom_data <= irom_addr[7:0] ^ irom_addr[15:8] ^ 8'h3C;

  // External bus: ROM content = addr[7:0] + 11, RAM is a small array.
  logic [7:0] ext_mem [256];
  always @(posedge clk) if (!ext_ram_wr_b) ext_mem[bus_addr[7:0]] <= bus_dout;
  assign bus_din = !ext_rom_rd_b ? bus_addr[7:0] + 8'h11 : ext_mem[bus_addr[7:0]];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int nreq = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, req);
    end
  endtask

  // Bus activity counters, sampled mid-cycle.
  int n_cs, n_rom, n_rd, n_wr, n_oe;
  int n_multi = 0;
  logic [15:0] wr_addr_seen;
  logic [7:0]  wr_data_seen;
  always @(negedge clk) begin
    if (!irom_cs_b)    n_cs++;
    if (!ext_rom_rd_b) n_rom++;
    if (!ext_ram_rd_b) n_rd++;
    if (!ext_ram_wr_b) begin
      n_wr++;
      wr_addr_seen = bus_addr;
      wr_data_seen = bus_dout;
    end
    if (oe) n_oe++;
    if (int'(!ext_rom_rd_b) + int'(!ext_ram_rd_b) + int'(!ext_ram_wr_b) > 1) n_multi++;
  end

  typedef struct {
    int         kind;
    logic [7:0] data;
    int         cyc;
    int         id;
  } exp_t;
  exp_t sb[$];
  exp_t mon_e;

  // Monitor: every ready pulse pops one expectation.
  always @(negedge clk) begin
    if (!rst && ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_ready: got ready at cycle %0d expected none", cyc);
      end else begin
        mon_e = sb.pop_front();
        check($sformatf("req%0d_latency", mon_e.id), cyc, mon_e.cyc);
        if (mon_e.kind == K_RAM)
          check($sformatf("req%0d_ram_data", mon_e.id), {24'h0, ram_rdata}, {24'h0, mon_e.data});
        else if (mon_e.kind == K_ROM)
          check($sformatf("req%0d_rom_data", mon_e.id), {24'h0, rom_data}, {24'h0, mon_e.data});
      end
    end
  end

  // Called just after the acceptance cycle has begun; ready arrives lat edges
  // after the acceptance edge.
  task automatic push_exp(input int kind, input logic [7:0] d, input int lat);
    exp_t e;
    e.kind = kind;
    e.data = d;
    e.cyc  = cyc + 1 + lat;
    e.id   = nreq;
    nreq++;
    sb.push_back(e);
  endtask

  task automatic wait_ready();
    int n = 0;
    @(negedge clk);
    while (!ready && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (!ready) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout: got no ready after %0d cycles expected ready", n);
    end
  endtask

  task automatic release_all();
    rom_rd_b = 1'b1;
    ram_rd_b = 1'b1;
    ram_wr_b = 1'b1;
    bit_flag = 1'b0;
    ext_ram  = 1'b0;
  endtask

  task automatic clr_cnt();
    n_cs = 0; n_rom = 0; n_rd = 0; n_wr = 0; n_oe = 0;
  endtask

  task automatic ram_acc(input logic wr, input logic bitf, input logic ext,
                         input logic [7:0] a, input logic [7:0] d, input logic [2:0] w,
                         input int kind, input logic [7:0] expd, input int lat);
    clr_cnt();
    ram_addr  = a;
    ram_wdata = d;
    bit_flag  = bitf;
    ext_ram   = ext;
    ws        = w;
    if (wr) ram_wr_b = 1'b0;
    else    ram_rd_b = 1'b0;
    push_exp(kind, expd, lat);
    wait_ready();
    @(posedge clk); #1;
    release_all();
  endtask

  task automatic fetch(input logic [15:0] a, input logic eab, input logic [2:0] w,
                       input logic [7:0] expd, input int lat);
    clr_cnt();
    rom_addr = a;
    ea_b     = eab;
    ws       = w;
    rom_rd_b = 1'b0;
    push_exp(K_ROM, expd, lat);
    wait_ready();
    @(posedge clk); #1;
    release_all();
    ea_b = 1'b1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int n;
    release_all();
    ea_b = 1'b1; ws = 3'd0; rom_addr = 16'h0; ram_addr = 8'h0; ram_wdata = 8'h0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", {31'h0, ready}, 32'h0);
    check("rst_strobes", {29'h0, ext_rom_rd_b, ext_ram_rd_b, ext_ram_wr_b}, 32'h7);
    check("rst_irom_cs_b", {31'h0, irom_cs_b}, 32'h1);
    check("rst_oe", {31'h0, oe}, 32'h0);
    check("rst_bus_addr", {16'h0, bus_addr}, 32'h0);
    check("rst_data_outs", {16'h0, rom_data, ram_rdata}, 32'h0);
    rst = 1'b0;

    // Byte writes then reads, L=1.
    for (int a = 0; a < 128; a++) ram_acc(1'b1, 1'b0, 1'b0, 8'(a), 8'(a) ^ 8'hA5, 3'd0, K_NONE, 8'h00, 1);
    for (int a = 0; a < 128; a++) ram_acc(1'b0, 1'b0, 1'b0, 8'(a), 8'h00, 3'd0, K_RAM, 8'(a) ^ 8'hA5, 1);
    ram_acc(1'b1, 1'b0, 1'b0, 8'hFF, 8'h3C, 3'd0, K_NONE, 8'h00, 1);
    ram_acc(1'b0, 1'b0, 1'b0, 8'hFF, 8'h00, 3'd0, K_RAM, 8'h3C, 1);

    // Bit accesses.
    ram_acc(1'b1, 1'b0, 1'b0, 8'h21, 8'h00, 3'd0, K_NONE, 8'h00, 1);
    ram_acc(1'b1, 1'b1, 1'b0, 8'h0B, 8'h01, 3'd0, K_NONE, 8'h00, 2);
    ram_acc(1'b0, 1'b0, 1'b0, 8'h21, 8'h00, 3'd0, K_RAM, 8'h08, 1);
    ram_acc(1'b0, 1'b1, 1'b0, 8'h0B, 8'h00, 3'd0, K_RAM, 8'h01, 1);
    ram_acc(1'b0, 1'b1, 1'b0, 8'h0A, 8'h00, 3'd0, K_RAM, 8'h00, 1);
    ram_acc(1'b1, 1'b1, 1'b0, 8'h0C, 8'h01, 3'd0, K_NONE, 8'h00, 2);
    ram_acc(1'b0, 1'b0, 1'b0, 8'h21, 8'h00, 3'd0, K_RAM, 8'h18, 1);
    ram_acc(1'b1, 1'b0, 1'b0, 8'h80, 8'hFF, 3'd0, K_NONE, 8'h00, 1);
    ram_acc(1'b1, 1'b1, 1'b0, 8'h85, 8'hFE, 3'd0, K_NONE, 8'h00, 2);
    ram_acc(1'b0, 1'b0, 1'b0, 8'h80, 8'h00, 3'd0, K_RAM, 8'hDF, 1);

    // Fetches: internal boundary, external by address, by ea_b, max wait states.
    fetch(16'h0FFF, 1'b1, 3'd0, 8'hCC, 2);
    check("irom_cs_cycles", n_cs, 1);
    check("irom_no_ext_strobe", n_rom, 0);
    fetch(16'h1000, 1'b1, 3'd0, 8'h11, 3);
    check("ext_rom_strobe_cycles", n_rom, 1);
    check("ext_rom_no_irom", n_cs, 0);
    fetch(16'h0010, 1'b0, 3'd0, 8'h21, 3);
    check("ea_b_forces_ext", n_rom, 1);
    fetch(16'h2345, 1'b1, 3'd7, 8'h56, 10);
    check("ws_max_strobe_cycles", n_rom, 8);

    // External RAM write with ws=3, then read back with bit flag ignored.
    ram_acc(1'b1, 1'b0, 1'b1, 8'h34, 8'h5A, 3'd3, K_NONE, 8'h00, 6);
    check("ext_wr_oe_cycles", n_oe, 6);
    check("ext_wr_strobe_cycles", n_wr, 4);
    check("ext_wr_addr", {16'h0, wr_addr_seen}, 32'h0034);
    check("ext_wr_data", {24'h0, wr_data_seen}, 32'h5A);
    check("ready_single_cycle", {31'h0, ready}, 32'h0);
    ram_acc(1'b0, 1'b1, 1'b1, 8'h34, 8'h00, 3'd1, K_RAM, 8'h5A, 4);
    check("ext_rd_strobe_cycles", n_rd, 2);
    check("ext_rd_no_oe", n_oe, 0);

    // Reset during STROBE of an external read.
    clr_cnt();
    ram_addr = 8'h34; ext_ram = 1'b1; ws = 3'd3; ram_rd_b = 1'b0;
    n = 0;
    @(negedge clk);
    while (ext_ram_rd_b && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("strobe_reached", {31'h0, ext_ram_rd_b}, 32'h0);
    rst = 1'b1;
    release_all();
    @(posedge clk); #1;
    check("midrst_strobes", {29'h0, ext_rom_rd_b, ext_ram_rd_b, ext_ram_wr_b}, 32'h7);
    check("midrst_oe", {31'h0, oe}, 32'h0);
    check("midrst_ready", {31'h0, ready}, 32'h0);
    check("midrst_data_outs", {16'h0, rom_data, ram_rdata}, 32'h0);
    rst = 1'b0;
    ram_acc(1'b0, 1'b0, 1'b0, 8'h21, 8'h00, 3'd0, K_RAM, 8'h18, 1);

    // All three requests together: write, then read, then fetch.
    clr_cnt();
    ram_addr = 8'h50; ram_wdata = 8'h77; rom_addr = 16'h0005; ea_b = 1'b1; ws = 3'd0;
    ram_wr_b = 1'b0; ram_rd_b = 1'b0; rom_rd_b = 1'b0;
    push_exp(K_NONE, 8'h00, 1);
    wait_ready();
    @(posedge clk); #1;
    ram_wr_b = 1'b1;
    push_exp(K_RAM, 8'h77, 1);
    wait_ready();
    @(posedge clk); #1;
    ram_rd_b = 1'b1;
    push_exp(K_ROM, 8'h39, 2);
    wait_ready();
    @(posedge clk); #1;
    rom_rd_b = 1'b1;
    check("prio_single_irom_cycle", n_cs, 1);

    repeat (4) @(posedge clk);
    #1;
    check("scoreboard_drained", sb.size(), 0);
    check("one_strobe_at_a_time", n_multi, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
